// File: rtl/cofre_alarme_seq.sv
// Vault-alarm controller: watches the vault doors against the time-lock
// clock and the manager panic switch, runs a grace period before alarming,
// latches the alarm until acknowledged and counts alarm entries.
// Optional door capture on alarm entry: define CAPTURA_PORTAS_EN.
module cofre_alarme_seq #(
    parameter int NPORTAS         = 4,
    parameter int CARENCIA_CICLOS = 4,
    parameter int NBITS_CNT       = 8
) (
    input  logic                 clk_2,
    input  logic                 reset,
    input  logic [NPORTAS-1:0]   porta_cofre,
    input  logic                 relogio_eletronico,
    input  logic                 interruptor_gerente,
    input  logic                 reconhece,
    output logic                 alarme,
    output logic                 pre_alarme,
    output logic [1:0]           estado,
    output logic [NBITS_CNT-1:0] contagem_alarmes,
    output logic [NPORTAS-1:0]   portas_violadas
);

    typedef enum logic [1:0] {
        OCIOSO      = 2'b00,
        CARENCIA    = 2'b01,
        ALARME      = 2'b10,
        RECONHECIDO = 2'b11
    } estado_t;

    // Timer only ever counts up to CARENCIA_CICLOS-1; keep at least one bit.
    localparam int TW   = (CARENCIA_CICLOS < 1) ? 1 : $clog2(CARENCIA_CICLOS + 1);
    localparam int TMAX = (CARENCIA_CICLOS < 1) ? 0 : CARENCIA_CICLOS - 1;

    estado_t           estado_q, estado_nxt;
    logic [TW-1:0]     timer_q, timer_nxt;
    logic [NBITS_CNT-1:0] cnt_q;

    logic aberta, panico, violacao, entra_alarme;

    assign aberta   = |(~porta_cofre);
    assign panico   = aberta & interruptor_gerente;
    assign violacao = aberta & (~relogio_eletronico | interruptor_gerente);

    // An edge that moves the FSM into ALARME from any other state.
    assign entra_alarme = (estado_nxt == ALARME) && (estado_q != ALARME);

    // State and grace-timer registers.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            estado_q <= OCIOSO;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_nxt;
            timer_q  <= timer_nxt;
        end
    end

    // Next-state and grace-timer logic; first matching rule wins.
    always_comb begin
        estado_nxt = estado_q;
        timer_nxt  = '0;
        unique case (estado_q)
            OCIOSO: begin
                if (panico)
                    estado_nxt = ALARME;
                else if (violacao) begin
                    // A zero-length grace period alarms immediately.
                    if (CARENCIA_CICLOS == 0)
                        estado_nxt = ALARME;
                    else
                        estado_nxt = CARENCIA;
                end
            end
            CARENCIA: begin
                if (panico)
                    estado_nxt = ALARME;
                else if (!violacao)
                    estado_nxt = OCIOSO;
                else if (timer_q == TW'(TMAX))
                    estado_nxt = ALARME;
                else
                    timer_nxt = timer_q + TW'(1);
            end
            ALARME: begin
                // Clearing the violation does not release the alarm.
                if (reconhece)
                    estado_nxt = RECONHECIDO;
            end
            RECONHECIDO: begin
                if (panico)
                    estado_nxt = ALARME;
                else if (&porta_cofre)
                    estado_nxt = OCIOSO;
            end
            default: estado_nxt = OCIOSO;
        endcase
    end

    // Saturating count of alarm entries.
    always_ff @(posedge clk_2) begin
        if (reset)
            cnt_q <= '0;
        else if (entra_alarme && (cnt_q != '1))
            cnt_q <= cnt_q + NBITS_CNT'(1);
    end

`ifdef CAPTURA_PORTAS_EN
    logic [NPORTAS-1:0] cap_q;

    // Snapshot the open doors on alarm entry; clear once the vault is closed again.
    always_ff @(posedge clk_2) begin
        if (reset)
            cap_q <= '0;
        else if (entra_alarme)
            cap_q <= ~porta_cofre;
        else if (estado_q == RECONHECIDO && estado_nxt == OCIOSO)
            cap_q <= '0;
    end

    assign portas_violadas = cap_q;
`else
    assign portas_violadas = '0;
`endif

    // Outputs decoded from registered state only.
    always_comb begin
        estado           = estado_q;
        alarme           = (estado_q == ALARME);
        pre_alarme       = (estado_q == CARENCIA);
        contagem_alarmes = cnt_q;
    end

endmodule
